// File: rtl/redmule_stream_addrgen_if.sv
// Streamer control bundle between the RedMulE scheduler/TCDM streamer (master)
// and one stream-channel address generator (slave).
interface redmule_stream_addrgen_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned LW = 16,
   parameter int unsigned TW = 32
);
   logic          req_start_i;
   logic [AW-1:0] base_addr_i;
   logic [TW-1:0] tot_len_i;
   logic [LW-1:0] d0_len_i;
   logic [AW-1:0] d0_stride_i;
   logic [LW-1:0] d1_len_i;
   logic [AW-1:0] d1_stride_i;
   logic [AW-1:0] d2_stride_i;
   logic [1:0]    dim_enable_1h_i;
   logic          ready_start_o;
   logic          done_o;
   logic          addr_valid_o;
   logic          addr_ready_i;
   logic [AW-1:0] addr_o;
   logic          addr_last_o;

   modport master (
      output req_start_i, base_addr_i, tot_len_i, d0_len_i, d0_stride_i,
             d1_len_i, d1_stride_i, d2_stride_i, dim_enable_1h_i, addr_ready_i,
      input  ready_start_o, done_o, addr_valid_o, addr_o, addr_last_o
   );

   modport slave (
      input  req_start_i, base_addr_i, tot_len_i, d0_len_i, d0_stride_i,
             d1_len_i, d1_stride_i, d2_stride_i, dim_enable_1h_i, addr_ready_i,
      output ready_start_o, done_o, addr_valid_o, addr_o, addr_last_o
   );
endinterface

// File: rtl/redmule_stream_addrgen.sv
// 3D strided address generator for one RedMulE stream channel: latches a descriptor
// on start, emits one address per valid/ready beat, then pulses done for one cycle.
module redmule_stream_addrgen #(
   parameter int unsigned AW = 32,
   parameter int unsigned LW = 16,
   parameter int unsigned TW = 32
) (
   input logic                   clk_i,
   input logic                   rst_i,
   input logic                   clear_i,
   redmule_stream_addrgen_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [TW-1:0] beat_cnt_q, beat_cnt_d;
   logic [TW-1:0] tot_len_q, tot_len_d;
   logic [LW-1:0] d0_cnt_q, d0_cnt_d;
   logic [LW-1:0] d1_cnt_q, d1_cnt_d;
   logic [LW-1:0] d0_last_q, d0_last_d;
   logic [LW-1:0] d1_last_q, d1_last_d;
   logic [AW-1:0] d0_stride_q, d0_stride_d;
   logic [AW-1:0] rew1_q, rew1_d;
   logic [AW-1:0] rew2_q, rew2_d;
   logic [1:0]    en_q, en_d;
   logic          last_q, last_d;

   logic [LW-1:0] d0_m1, d1_m1;
   logic [AW-1:0] span0, span1;

   // Zero-length dimensions behave as length one.
   assign d0_m1 = (bus.d0_len_i == '0) ? '0 : bus.d0_len_i - LW'(1);
   assign d1_m1 = (bus.d1_len_i == '0) ? '0 : bus.d1_len_i - LW'(1);
   assign span0 = AW'(d0_m1) * bus.d0_stride_i;
   assign span1 = AW'(d1_m1) * bus.d1_stride_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      beat_cnt_d  = beat_cnt_q;
      tot_len_d   = tot_len_q;
      d0_cnt_d    = d0_cnt_q;
      d1_cnt_d    = d1_cnt_q;
      d0_last_d   = d0_last_q;
      d1_last_d   = d1_last_q;
      d0_stride_d = d0_stride_q;
      rew1_d      = rew1_q;
      rew2_d      = rew2_q;
      en_d        = en_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            if (bus.req_start_i) begin
               addr_d      = bus.base_addr_i;
               beat_cnt_d  = '0;
               d0_cnt_d    = '0;
               d1_cnt_d    = '0;
               tot_len_d   = bus.tot_len_i;
               d0_last_d   = d0_m1;
               d1_last_d   = d1_m1;
               d0_stride_d = bus.d0_stride_i;
               rew1_d      = bus.d1_stride_i - span0;
               rew2_d      = bus.d2_stride_i - span0 - span1;
               en_d        = bus.dim_enable_1h_i;
               last_d      = (bus.tot_len_i == TW'(1));
               state_d     = (bus.tot_len_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.addr_ready_i) begin
               beat_cnt_d = beat_cnt_q + TW'(1);
               last_d     = (beat_cnt_q + TW'(1) == tot_len_q - TW'(1));
               if (!en_q[0] || d0_cnt_q != d0_last_q) begin
                  d0_cnt_d = d0_cnt_q + LW'(1);
                  addr_d   = addr_q + d0_stride_q;
               end else begin
                  d0_cnt_d = '0;
                  if (!en_q[1] || d1_cnt_q != d1_last_q) begin
                     d1_cnt_d = d1_cnt_q + LW'(1);
                     addr_d   = addr_q + rew1_q;
                  end else begin
                     d1_cnt_d = '0;
                     addr_d   = addr_q + rew2_q;
                  end
               end
               if (last_q) begin
                  last_d  = 1'b0;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (clear_i) begin
         state_d    = IDLE;
         addr_d     = '0;
         beat_cnt_d = '0;
         d0_cnt_d   = '0;
         d1_cnt_d   = '0;
         last_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         beat_cnt_q  <= '0;
         tot_len_q   <= '0;
         d0_cnt_q    <= '0;
         d1_cnt_q    <= '0;
         d0_last_q   <= '0;
         d1_last_q   <= '0;
         d0_stride_q <= '0;
         rew1_q      <= '0;
         rew2_q      <= '0;
         en_q        <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beat_cnt_q  <= beat_cnt_d;
         tot_len_q   <= tot_len_d;
         d0_cnt_q    <= d0_cnt_d;
         d1_cnt_q    <= d1_cnt_d;
         d0_last_q   <= d0_last_d;
         d1_last_q   <= d1_last_d;
         d0_stride_q <= d0_stride_d;
         rew1_q      <= rew1_d;
         rew2_q      <= rew2_d;
         en_q        <= en_d;
         last_q      <= last_d;
      end
   end

   assign bus.ready_start_o = (state_q == IDLE);
   assign bus.done_o        = (state_q == DONE);
   assign bus.addr_valid_o  = (state_q == RUN);
   assign bus.addr_o        = addr_q;
   assign bus.addr_last_o   = last_q;
endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// Directed table-driven bench for redmule_stream_addrgen plus hand-written abort,
// zero-length, busy-request and backpressure sequences.
module tb_redmule_stream_addrgen;
   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   n_vec = 0;
   int   n_bad = 0;

   redmule_stream_addrgen_if #(.AW(32), .LW(16), .TW(32)) bus ();

   redmule_stream_addrgen #(.AW(32), .LW(16), .TW(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      int          n;
      logic [15:0] d0len;
      logic [31:0] d0s;
      logic [15:0] d1len;
      logic [31:0] d1s;
      logic [31:0] d2s;
      logic [1:0]  en;
      logic [31:0] exp [8];
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      bus.base_addr_i     = $urandom;
      bus.tot_len_i       = $urandom;
      bus.d0_len_i        = 16'($urandom);
      bus.d0_stride_i     = $urandom;
      bus.d1_len_i        = 16'($urandom);
      bus.d1_stride_i     = $urandom;
      bus.d2_stride_i     = $urandom;
      bus.dim_enable_1h_i = 2'($urandom);
   endtask

   task automatic start(input int vi);
      bus.base_addr_i     = tbl[vi].base;
      bus.tot_len_i       = tbl[vi].n;
      bus.d0_len_i        = tbl[vi].d0len;
      bus.d0_stride_i     = tbl[vi].d0s;
      bus.d1_len_i        = tbl[vi].d1len;
      bus.d1_stride_i     = tbl[vi].d1s;
      bus.d2_stride_i     = tbl[vi].d2s;
      bus.dim_enable_1h_i = tbl[vi].en;
      bus.req_start_i     = 1'b1;
      step();
      bus.req_start_i     = 1'b0;
      scramble();
   endtask

   task automatic run_vec(input int vi, input bit rnd, input bit busy);
      int k   = 0;
      int cyc = 0;
      bit hs;
      chk($sformatf("v%0d idle_ready", vi), 64'(bus.ready_start_o), 64'd1);
      bus.addr_ready_i = 1'b1;
      start(vi);
      while (k < tbl[vi].n && cyc < 200) begin
         chk($sformatf("v%0d b%0d valid", vi, k), 64'(bus.addr_valid_o), 64'd1);
         chk($sformatf("v%0d b%0d addr", vi, k), 64'(bus.addr_o), 64'(tbl[vi].exp[k]));
         chk($sformatf("v%0d b%0d last", vi, k), 64'(bus.addr_last_o), 64'(k == tbl[vi].n - 1));
         chk($sformatf("v%0d b%0d done", vi, k), 64'(bus.done_o), 64'd0);
         bus.req_start_i  = busy && (cyc == 1);
         bus.addr_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = bus.addr_ready_i;
         step();
         if (hs) k++;
         cyc++;
      end
      bus.req_start_i = 1'b0;
      if (cyc >= 200) chk($sformatf("v%0d timeout beats", vi), 64'(k), 64'(tbl[vi].n));
      chk($sformatf("v%0d done_pulse", vi), 64'(bus.done_o), 64'd1);
      chk($sformatf("v%0d valid_after", vi), 64'(bus.addr_valid_o), 64'd0);
      step();
      chk($sformatf("v%0d done_clear", vi), 64'(bus.done_o), 64'd0);
      chk($sformatf("v%0d ready_back", vi), 64'(bus.ready_start_o), 64'd1);
      chk($sformatf("v%0d no_restart", vi), 64'(bus.addr_valid_o), 64'd0);
   endtask

   initial begin
      tbl[0] = '{32'h1000, 4, 16'd1, 32'h0, 16'd4, 32'h40, 32'h0, 2'b11,
                 '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 0, 0, 0, 0}};
      tbl[1] = '{32'h0, 6, 16'd2, 32'h4, 16'd2, 32'h100, 32'h1000, 2'b11,
                 '{32'h0, 32'h4, 32'h100, 32'h104, 32'h1000, 32'h1004, 0, 0}};
      tbl[2] = '{32'hFFFF_FFF8, 4, 16'd4, 32'h4, 16'd0, 32'h0, 32'h0, 2'b01,
                 '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 0, 0, 0, 0}};
      tbl[3] = '{32'h200, 5, 16'd2, 32'h8, 16'd3, 32'h1000, 32'h5000, 2'b00,
                 '{32'h200, 32'h208, 32'h210, 32'h218, 32'h220, 0, 0, 0}};
      tbl[4] = '{32'h10, 3, 16'd0, 32'h4, 16'd1, 32'h20, 32'h9000, 2'b01,
                 '{32'h10, 32'h30, 32'h50, 0, 0, 0, 0, 0}};
      tbl[5] = '{32'h0, 4, 16'd3, 32'h1, 16'd2, 32'h10, 32'h100, 2'b11,
                 '{32'h0, 32'h1, 32'h2, 32'h10, 0, 0, 0, 0}};
      tbl[6] = '{32'hABC, 1, 16'd2, 32'h4, 16'd2, 32'h8, 32'h10, 2'b11,
                 '{32'hABC, 0, 0, 0, 0, 0, 0, 0}};

      rst   = 1'b1;
      clear = 1'b0;
      bus.req_start_i  = 1'b0;
      bus.addr_ready_i = 1'b0;
      scramble();
      #12;
      chk("rst ready_start", 64'(bus.ready_start_o), 64'd1);
      chk("rst done", 64'(bus.done_o), 64'd0);
      chk("rst valid", 64'(bus.addr_valid_o), 64'd0);
      chk("rst last", 64'(bus.addr_last_o), 64'd0);
      chk("rst addr", 64'(bus.addr_o), 64'd0);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) run_vec(i, 1'b0, 1'b0);

      // Backpressure on the 3D stream, then a busy request ignored mid-run.
      run_vec(1, 1'b1, 1'b0);
      run_vec(0, 1'b0, 1'b1);

      // Zero-length stream.
      bus.base_addr_i = 32'h500;
      bus.tot_len_i   = 0;
      bus.req_start_i = 1'b1;
      step();
      bus.req_start_i = 1'b0;
      chk("zero valid", 64'(bus.addr_valid_o), 64'd0);
      chk("zero done", 64'(bus.done_o), 64'd1);
      chk("zero busy", 64'(bus.ready_start_o), 64'd0);
      step();
      chk("zero done_clear", 64'(bus.done_o), 64'd0);
      chk("zero idle", 64'(bus.ready_start_o), 64'd1);
      chk("zero no_beat", 64'(bus.addr_valid_o), 64'd0);

      // Synchronous clear while beat 2 is presented.
      bus.addr_ready_i = 1'b1;
      start(0);
      step();
      step();
      chk("clr beat2 addr", 64'(bus.addr_o), 64'h1080);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr valid", 64'(bus.addr_valid_o), 64'd0);
      chk("clr done", 64'(bus.done_o), 64'd0);
      chk("clr ready_start", 64'(bus.ready_start_o), 64'd1);
      chk("clr addr", 64'(bus.addr_o), 64'd0);
      chk("clr last", 64'(bus.addr_last_o), 64'd0);
      step();
      chk("clr no_done", 64'(bus.done_o), 64'd0);
      run_vec(0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream, asserted away from the clock edge.
      start(1);
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst valid", 64'(bus.addr_valid_o), 64'd0);
      chk("arst ready_start", 64'(bus.ready_start_o), 64'd1);
      chk("arst addr", 64'(bus.addr_o), 64'd0);
      chk("arst done", 64'(bus.done_o), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("arst no_done", 64'(bus.done_o), 64'd0);
      chk("arst idle", 64'(bus.ready_start_o), 64'd1);
      run_vec(1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
